inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
- Requester side of the sequencer instruction ROM read interface: issues rden/addr reads, absorbs the ROM's fixed COMMON_BRAM_DELAY read latency, and presents instructions in order to the decoder over a valid/ready handshake.
- A credit-limited skid FIFO allows full-rate streaming under decoder backpressure without losing in-flight ROM data.
- Sits between the sequencer control (start/done) and the instruction ROM.

Parameters:
- DWIDTH, `COE_WIDTH, instruction word width
- DEPTH, `IQUEUE_DEPTH, ROM depth in words
- AWIDTH, $clog2(DEPTH), ROM address width
- COMMON_BRAM_DELAY, `COMMON_BRAM_DELAY, ROM read latency in cycles (>=1)
- FIFO_DEPTH, COMMON_BRAM_DELAY+2, skid FIFO entries (must be >= COMMON_BRAM_DELAY+1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse, begin fetch program
- start_pc  in  AWIDTH  first ROM address
- inst_num  in  AWIDTH+1  number of instructions to fetch
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last instruction handshake
- rom_rden  out  1  ROM read enable
- rom_addr  out  AWIDTH  ROM read address
- rom_vld  in  1  ROM data valid, COMMON_BRAM_DELAY cycles after rom_rden
- rom_dout  in  DWIDTH  ROM read data
- inst_vld  out  1  instruction valid to decoder
- inst_data  out  DWIDTH  instruction word
- inst_pc  out  AWIDTH  ROM address of inst_data
- inst_rdy  in  1  decoder ready

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values:
  - busy, done, rom_rden, inst_vld = 0.
  - rom_addr, inst_pc, inst_data = 0.
  - FIFO empty; inflight = 0; state IDLE.
- State IDLE:
  - start=1 latches pc=start_pc and remain=inst_num.
  - If inst_num!=0, go to FETCH.
  - If inst_num==0, done pulses next cycle; no reads are issued; busy stays 0.
  - start while not IDLE is ignored.
- State FETCH: rom_rden=1 when remain!=0 and (fifo_count+inflight) < FIFO_DEPTH.
  - Each issue: rom_addr=pc; pc = (pc==DEPTH-1) ? 0 : pc+1; remain decrements.
  - When remain reaches 0, go to DRAIN.
- inflight counter: +1 on rom_rden, -1 on rom_vld; a simultaneous +1/-1 leaves it unchanged.
- rom_vld writes {rom_dout, its pc} into the FIFO.
  - The credit rule guarantees no overflow; overflow is an assertion failure.
  - rom_vld while inflight==0 (stale) is dropped.
- The FIFO is first-word-fall-through with registered outputs.
  - inst_vld = FIFO not empty.
  - Pop on inst_vld & inst_rdy.
  - inst_data and inst_pc are stable while inst_vld=1 and inst_rdy=0.
- State DRAIN: when delivered count == inst_num and inflight==0, pulse done for 1 cycle, clear busy, return to IDLE.
- Latency (start in cycle 0):
  - rom_rden in cycle 1.
  - rom_vld in cycle 1+D.
  - inst_vld in cycle 2+D.
- Throughput: 1 instruction/cycle while inst_rdy=1.
- Simultaneous FIFO push and pop: occupancy is unchanged.
- Reset mid-operation: everything clears on the next edge; late rom_vld is dropped as stale.

Optional Feature:
- Macro: IFETCH_ABORT_EN.
- Defined:
  - Adds input `abort` and output `aborted` (1-cycle pulse).
  - abort in FETCH/DRAIN stops issuing and enters FLUSH.
  - FLUSH forces inst_vld=0 and discards returning rom_vld data and the FIFO contents.
  - When inflight==0, FLUSH pulses `aborted` (not done) and returns to IDLE.
  - abort in IDLE is ignored.
- Not defined: no ports added; there is no FLUSH state.

Decomposition:
- Shared vp defines/package:
  - state encoding (IDLE, FETCH, DRAIN, FLUSH)
  - default FIFO_DEPTH expression
- Sub-module sync_fifo_fwft (DWIDTH+AWIDTH wide, FIFO_DEPTH entries, count output), instanced once.
- ROM connection: pairs directly with inst_rom (rden/addr/o_vld/dout).

Test Plan:
- D=2, DEPTH=16, start_pc=3, inst_num=5, inst_rdy=1 -> rom_rden cycles 1-5; inst_pc 3,4,5,6,7 on consecutive cycles from cycle 4; done 1 cycle after the last handshake.
- start_pc=14, inst_num=4 -> inst_pc 14,15,0,1 (wrap-around); data matches ROM contents.
- inst_rdy=0 for 10 cycles mid-stream -> reads stall when fifo_count+inflight==FIFO_DEPTH; no word lost or duplicated; inst_data held stable.
- inst_num=0 -> done pulses cycle 1; rom_rden never asserted; busy stays 0.
- rst asserted in the cycle after 2 reads are in flight -> all outputs 0 next cycle; late rom_vld ignored; a new start_pc=0, inst_num=2 fetch runs correctly.
- IFETCH_ABORT_EN: abort at cycle 3 of a 10-word fetch -> no inst_vld after abort; `aborted` pulses once inflight drains; done never pulses.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: state encoding and sizing defaults shared by inst_fetch; IFETCH_ABORT_EN adds the FLUSH state
`ifndef COE_WIDTH
`define COE_WIDTH 32
`endif
`ifndef IQUEUE_DEPTH
`define IQUEUE_DEPTH 256
`endif
`ifndef COMMON_BRAM_DELAY
`define COMMON_BRAM_DELAY 2
`endif

package inst_fetch_pkg;

   localparam int DEF_DWIDTH     = `COE_WIDTH;
   localparam int DEF_DEPTH      = `IQUEUE_DEPTH;
   localparam int DEF_BRAM_DELAY = `COMMON_BRAM_DELAY;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
`ifdef IFETCH_ABORT_EN
      ,
      FLUSH
`endif
   } state_t;

   // One slot per word in the ROM pipeline, one for the request cycle, one to keep streaming under a pop
   function automatic int fifo_depth(input int delay);
      return delay + 2;
   endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO, output taken straight from storage flops, with occupancy count
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clr,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic                         vld,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;

   assign dout = mem[rd_ptr];
   assign vld  = (count != '0);

   // Circular storage; clr empties the queue without touching the stored words
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
         count <= count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
      end
   end

   overflow_a : assert property (@(posedge clk) disable iff (rst) !(push && !pop && !clr && count == FULL));

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: credit-limited instruction ROM reader feeding a decoder over valid/ready; IFETCH_ABORT_EN adds abort/aborted
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter int DWIDTH            = DEF_DWIDTH,
   parameter int DEPTH             = DEF_DEPTH,
   parameter int AWIDTH            = $clog2(DEPTH),
   parameter int COMMON_BRAM_DELAY = DEF_BRAM_DELAY,
   parameter int FIFO_DEPTH        = fifo_depth(COMMON_BRAM_DELAY)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [AWIDTH-1:0] start_pc,
   input  logic [AWIDTH:0]   inst_num,
   output logic              busy,
   output logic              done,
   output logic              rom_rden,
   output logic [AWIDTH-1:0] rom_addr,
   input  logic              rom_vld,
   input  logic [DWIDTH-1:0] rom_dout,
   output logic              inst_vld,
   output logic [DWIDTH-1:0] inst_data,
   output logic [AWIDTH-1:0] inst_pc,
`ifdef IFETCH_ABORT_EN
   input  logic              abort,
   output logic              aborted,
`endif
   input  logic              inst_rdy
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH - 1);
   localparam logic [CW:0]       FD   = (CW+1)'(FIFO_DEPTH);
   localparam logic [AWIDTH:0]   ONE  = (AWIDTH+1)'(1);

   state_t            state;
   logic [AWIDTH-1:0] pc, ret_pc;
   logic [AWIDTH:0]   remain, num, delivered;
   logic [CW-1:0]     inflight, fifo_count;
   logic [CW:0]       occ;
   logic              fifo_vld, flush, accept, push, pop, can_issue;

   function automatic logic [AWIDTH-1:0] nxt(input logic [AWIDTH-1:0] a);
      return (a == LAST) ? '0 : a + 1'b1;
   endfunction

`ifdef IFETCH_ABORT_EN
   assign flush = (state == FLUSH);
`else
   assign flush = 1'b0;
`endif

   assign inst_vld  = fifo_vld & ~flush;
   assign pop       = inst_vld & inst_rdy;
   assign accept    = rom_vld & (inflight != '0);
   assign push      = accept & ~flush;
   // Words committed after this cycle: queued + in flight + the request on the bus, less the word leaving now
   assign occ       = {1'b0, fifo_count} + {1'b0, inflight} + {{CW{1'b0}}, rom_rden} - {{CW{1'b0}}, pop};
   assign can_issue = (remain != '0) && (occ < FD);

   // Reads outstanding at the ROM; a return with nothing outstanding is stale and not counted
   always_ff @(posedge clk) begin
      if (rst) inflight <= '0;
      else inflight <= inflight + {{(CW-1){1'b0}}, rom_rden} - {{(CW-1){1'b0}}, accept};
   end

   // Control FSM driving the registered ROM request and status outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         busy      <= 1'b0;
         done      <= 1'b0;
         rom_rden  <= 1'b0;
         rom_addr  <= '0;
         pc        <= '0;
         ret_pc    <= '0;
         remain    <= '0;
         num       <= '0;
         delivered <= '0;
`ifdef IFETCH_ABORT_EN
         aborted   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
`ifdef IFETCH_ABORT_EN
         aborted <= 1'b0;
`endif
         if (push) ret_pc <= nxt(ret_pc);
         if (pop) delivered <= delivered + {{AWIDTH{1'b0}}, pop};
         case (state)
            IDLE: begin
               if (start) begin
                  num       <= inst_num;
                  delivered <= '0;
                  ret_pc    <= start_pc;
                  if (inst_num == '0) begin
                     done <= 1'b1;
                  end else begin
                     busy     <= 1'b1;
                     rom_rden <= 1'b1;
                     rom_addr <= start_pc;
                     pc       <= nxt(start_pc);
                     remain   <= inst_num - ONE;
                     state    <= (inst_num == ONE) ? DRAIN : FETCH;
                  end
               end
            end
            FETCH: begin
               rom_rden <= can_issue;
               if (can_issue) begin
                  rom_addr <= pc;
                  pc       <= nxt(pc);
                  remain   <= remain - ONE;
                  if (remain == ONE) state <= DRAIN;
               end
            end
            DRAIN: begin
               rom_rden <= 1'b0;
               if (!rom_rden && inflight == '0 && delivered + {{AWIDTH{1'b0}}, pop} == num) begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
`ifdef IFETCH_ABORT_EN
            FLUSH: begin
               rom_rden <= 1'b0;
               if (inflight == '0) begin
                  aborted <= 1'b1;
                  busy    <= 1'b0;
                  state   <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
`ifdef IFETCH_ABORT_EN
         if (abort && (state == FETCH || state == DRAIN)) begin
            rom_rden <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b1;
            state    <= FLUSH;
         end
`endif
      end
   end

   sync_fifo_fwft #(
      .WIDTH (DWIDTH + AWIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (flush),
      .push  (push),
      .pop   (pop),
      .din   ({rom_dout, ret_pc}),
      .dout  ({inst_data, inst_pc}),
      .vld   (fifo_vld),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: randomized self-checking bench for inst_fetch with a delayed-ROM responder and an in-order program model
module tb_inst_fetch;

   localparam int D     = 2;
   localparam int DEPTH = 16;
   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int FD    = D + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [AW-1:0] start_pc = '0;
   logic [AW:0]   inst_num = '0;
   logic          busy, done, rom_rden, inst_vld;
   logic [AW-1:0] rom_addr, inst_pc;
   logic          rom_vld = 1'b0;
   logic [DW-1:0] rom_dout = '0;
   logic [DW-1:0] inst_data;
   logic          inst_rdy = 1'b0;
`ifdef IFETCH_ABORT_EN
   logic          abort = 1'b0;
   logic          aborted;
`endif

   int total = 0;
   int bad = 0;

   logic [DW-1:0] rom [DEPTH];
   logic          pv [D+1];
   logic [AW-1:0] pa [D+1];

   always #5 clk = ~clk;

   inst_fetch #(
      .DWIDTH            (DW),
      .DEPTH             (DEPTH),
      .COMMON_BRAM_DELAY (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .start_pc  (start_pc),
      .inst_num  (inst_num),
      .busy      (busy),
      .done      (done),
      .rom_rden  (rom_rden),
      .rom_addr  (rom_addr),
      .rom_vld   (rom_vld),
      .rom_dout  (rom_dout),
      .inst_vld  (inst_vld),
      .inst_data (inst_data),
      .inst_pc   (inst_pc),
`ifdef IFETCH_ABORT_EN
      .abort     (abort),
      .aborted   (aborted),
`endif
      .inst_rdy  (inst_rdy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one cycle; the ROM answers each request D cycles later and never resets
   task automatic tick();
      @(posedge clk);
      #1;
      for (int i = D; i > 0; i--) begin
         pv[i] = pv[i-1];
         pa[i] = pa[i-1];
      end
      pv[0]    = rom_rden;
      pa[0]    = rom_addr;
      rom_vld  = pv[D];
      rom_dout = rom[pa[D]];
   endtask

   // mode 0: always ready, 1: random ready, 2: ready dropped for 10 cycles
   task automatic run(input int pc0, input int n, input int mode);
      int  exp_pc[$];
      int  issued, popped, last_hs, max_out;
      bit  fin;
      issued = 0; popped = 0; last_hs = 0; max_out = 0; fin = 0;
      for (int i = 0; i < n; i++) exp_pc.push_back((pc0 + i) % DEPTH);
      tick();
      start = 1'b1; start_pc = AW'(pc0); inst_num = (AW+1)'(n); inst_rdy = 1'b1;
      #1;
      for (int c = 1; c < 600 && !fin; c++) begin
         tick();
         start = 1'b0;
         inst_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : !(c >= 6 && c < 16);
         #1;
         if (mode == 0) chk("rden_time", rom_rden, (c >= 1 && c <= n));
         if (rom_rden) begin
            chk("rd_addr", rom_addr, (pc0 + issued) % DEPTH);
            issued++;
            if (issued - popped > max_out) max_out = issued - popped;
            chk("credit", (issued - popped) <= FD, 1);
         end
         if (inst_vld) begin
            if (exp_pc.size() == 0) chk("extra_word", 1, 0);
            else begin
               chk("inst_pc", inst_pc, exp_pc[0]);
               chk("inst_data", inst_data, rom[exp_pc[0]]);
               if (mode == 0 && popped == 0) chk("first_lat", c, 2 + D);
               if (inst_rdy) begin
                  void'(exp_pc.pop_front());
                  popped++;
                  last_hs = c;
               end
            end
         end
         if (done) begin
            chk("done_time", c, (n == 0) ? 1 : last_hs + 1);
            chk("done_count", popped, n);
            chk("busy_end", busy, 0);
            fin = 1;
         end else begin
            chk("busy", busy, n != 0);
         end
      end
      if (!fin) chk("done_timeout", 0, 1);
      chk("issued", issued, n);
      if (mode == 2) chk("stall_credit", max_out, FD);
      tick();
      #1;
      chk("done_pulse", done, 0);
      chk("idle_vld", inst_vld, 0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) rom[i] = DW'($urandom);
      for (int i = 0; i <= D; i++) begin
         pv[i] = 1'b0;
         pa[i] = '0;
      end
      repeat (3) tick();
      rst = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rden", rom_rden, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rst_vld", inst_vld, 0);
      chk("rst_pc", inst_pc, 0);
      chk("rst_data", inst_data, 0);

      run(3, 5, 0);
      run(14, 4, 0);
      run(5, 20, 2);
      run(7, 0, 0);

      // Reset while reads are in flight; their late returns must be dropped
      tick();
      start = 1'b1; start_pc = AW'(8); inst_num = (AW+1)'(6);
      #1;
      tick(); start = 1'b0; #1;
      tick(); #1;
      tick(); rst = 1'b1; #1;
      tick(); rst = 1'b0; #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_rden", rom_rden, 0);
      chk("mid_rst_vld", inst_vld, 0);
      chk("mid_rst_addr", rom_addr, 0);
      for (int i = 0; i < D + 3; i++) begin
         tick(); #1;
         chk("stale_vld", inst_vld, 0);
         chk("stale_busy", busy, 0);
      end
      run(0, 2, 0);

`ifdef IFETCH_ABORT_EN
      begin
         int na;
         na = 0;
         tick();
         start = 1'b1; start_pc = AW'(2); inst_num = (AW+1)'(10); inst_rdy = 1'b1;
         #1;
         for (int c = 1; c < 40; c++) begin
            tick();
            start = 1'b0;
            abort = (c == 3);
            #1;
            if (c > 3) chk("abort_vld", inst_vld, 0);
            chk("abort_done", done, 0);
            if (aborted) na++;
         end
         abort = 1'b0;
         chk("aborted_once", na, 1);
         chk("abort_busy", busy, 0);
         run(4, 3, 1);
      end
`endif

      for (int k = 0; k < 6; k++) run($urandom_range(0, DEPTH - 1), $urandom_range(1, 24), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
